// File: rtl/channel_pkg.sv
// Shared types and constants for the channel command-word engine.
// State encodings, command/status bit positions, condition codes.
package channel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACT,
    S_RUN,
    S_STOP_WAIT,
    S_FINISH
  } eng_state_t;

  localparam logic [7:0] CMD_TEST_IO   = 8'h00;
  localparam int         CMD_WRITE_BIT = 0;
  localparam int         STAT_DE_BIT   = 5;

  localparam logic [1:0] CC_OK        = 2'd0;
  localparam logic [1:0] CC_NOT_OPER  = 2'd3;

endpackage

// File: rtl/ccw_byte_counter.sv
// Byte counter: load on request, decrement on strobe, never below zero.
// Ports: clk, reset, load/load_value in; dec in; zero, residual out.
module ccw_byte_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   dec,
  output logic                   zero,
  output logic [COUNT_WIDTH-1:0] residual
);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero     = (count == '0);
  assign residual = count;

endmodule

// File: rtl/ccw_engine.sv
// Command-word executor driving the parallel channel block and bridging
// its send/receive streams to host AXI-Streams with byte-count enforcement.
// Ports: req_* request in, done_* completion record out, chan_* channel
// controls/streams, host_tx_* (to device), host_rx_* (from device).
// Optional: CCW_SLI_EN adds req_sli to suppress incorrect-length reports.
module ccw_engine
  import channel_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_addr,
  input  logic [7:0]             req_command,
  input  logic [COUNT_WIDTH-1:0] req_count,
`ifdef CCW_SLI_EN
  input  logic                   req_sli,
`endif
  output logic                   done_valid,
  output logic [1:0]             done_cc,
  output logic [7:0]             done_status,
  output logic [COUNT_WIDTH-1:0] done_residual,
  output logic                   done_incorrect_length,
  output logic [7:0]             chan_addr,
  output logic [7:0]             chan_command,
  output logic                   chan_start,
  output logic                   chan_stop,
  input  logic                   chan_active,
  input  logic [1:0]             chan_condition_code,
  input  logic [7:0]             chan_status_tdata,
  input  logic                   chan_status_tvalid,
  output logic [7:0]             chan_send_tdata,
  output logic                   chan_send_tvalid,
  input  logic                   chan_send_tready,
  input  logic [7:0]             chan_recv_tdata,
  input  logic                   chan_recv_tvalid,
  output logic                   chan_recv_tready,
  input  logic [7:0]             host_tx_tdata,
  input  logic                   host_tx_tvalid,
  output logic                   host_tx_tready,
  output logic [7:0]             host_rx_tdata,
  output logic                   host_rx_tvalid,
  input  logic                   host_rx_tready
);

  eng_state_t state, state_next;

  logic [7:0] addr_q;
  logic [7:0] cmd_q;
  logic [7:0] status_q;
  logic       stopped_q;
  logic       wait_q;
  logic       sli_q;

  logic                   zero;
  logic [COUNT_WIDTH-1:0] residual;

  logic accept;
  logic is_write;
  logic xfer_ok;
  logic wr_path;
  logic rd_path;
  logic dec;
  logic overrun;
  logic stop_fire;
  logic fin;

  assign accept   = req_valid && (state == S_IDLE);
  assign is_write = cmd_q[CMD_WRITE_BIT];
  assign xfer_ok  = (state == S_RUN) && !zero;
  assign wr_path  = xfer_ok && is_write;
  assign rd_path  = xfer_ok && !is_write;
  assign fin      = (state == S_FINISH);

  // Streams are wired straight through only while bytes remain.
  assign chan_send_tvalid = wr_path && host_tx_tvalid;
  assign chan_send_tdata  = wr_path ? host_tx_tdata : 8'h00;
  assign host_tx_tready   = wr_path && chan_send_tready;

  assign host_rx_tvalid   = rd_path && chan_recv_tvalid;
  assign host_rx_tdata    = rd_path ? chan_recv_tdata : 8'h00;
  assign chan_recv_tready = rd_path && host_rx_tready;

  assign dec = (wr_path && host_tx_tvalid && chan_send_tready)
            || (rd_path && chan_recv_tvalid && host_rx_tready);

  // Device asks for a byte the count no longer allows.
  assign overrun = zero
                && (is_write ? chan_send_tready : chan_recv_tvalid);
  assign stop_fire = (state == S_RUN) && chan_active && overrun;

  ccw_byte_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (req_count),
    .dec        (dec),
    .zero       (zero),
    .residual   (residual)
  );

  always_comb begin
    state_next = state;
    chan_start = 1'b0;
    chan_stop  = 1'b0;
    done_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) state_next = S_START;
      end
      S_START: begin
        chan_start = 1'b1;
        state_next = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (chan_active) state_next = S_RUN;
        else if (wait_q) state_next = S_FINISH;
      end
      S_RUN: begin
        if (!chan_active) begin
          state_next = S_FINISH;
        end else if (overrun) begin
          chan_stop  = 1'b1;
          state_next = S_STOP_WAIT;
        end
      end
      S_STOP_WAIT: begin
        if (!chan_send_tready && !chan_recv_tvalid)
          state_next = S_RUN;
      end
      S_FINISH: begin
        done_valid = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= 8'h00;
      cmd_q     <= 8'h00;
      status_q  <= 8'h00;
      stopped_q <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      state  <= state_next;
      wait_q <= (state == S_WAIT_ACT);
      if (accept) begin
        addr_q    <= req_addr;
        cmd_q     <= req_command;
        status_q  <= 8'h00;
        stopped_q <= 1'b0;
      end else begin
        if (state != S_IDLE && chan_status_tvalid)
          status_q <= chan_status_tdata;
        if (stop_fire)
          stopped_q <= 1'b1;
      end
    end
  end

`ifdef CCW_SLI_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sli_q <= 1'b0;
    else if (accept) sli_q <= req_sli;
  end
`else
  assign sli_q = 1'b0;
`endif

  assign req_ready     = (state == S_IDLE);
  assign chan_addr     = addr_q;
  assign chan_command  = cmd_q;
  assign done_cc       = fin ? chan_condition_code : CC_OK;
  assign done_status   = fin ? status_q : 8'h00;
  assign done_residual = fin ? residual : '0;

  // TEST_IO ignores the count; only a stop makes it a length error.
  assign done_incorrect_length = fin && !sli_q
    && (stopped_q || (!zero && cmd_q != CMD_TEST_IO));

endmodule

// File: tb/tb_ccw_engine.sv
// Scoreboard bench for ccw_engine: directed operations against a small
// channel/device model; a monitor checks bytes and completion records.
module tb_ccw_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [7:0]  req_command;
  logic [15:0] req_count;
`ifdef CCW_SLI_EN
  logic        req_sli;
`endif
  logic        done_valid;
  logic [1:0]  done_cc;
  logic [7:0]  done_status;
  logic [15:0] done_residual;
  logic        done_incorrect_length;
  logic [7:0]  chan_addr;
  logic [7:0]  chan_command;
  logic        chan_start;
  logic        chan_stop;
  logic        chan_active;
  logic [1:0]  chan_condition_code;
  logic [7:0]  chan_status_tdata;
  logic        chan_status_tvalid;
  logic [7:0]  chan_send_tdata;
  logic        chan_send_tvalid;
  logic        chan_send_tready;
  logic [7:0]  chan_recv_tdata;
  logic        chan_recv_tvalid;
  logic        chan_recv_tready;
  logic [7:0]  host_tx_tdata;
  logic        host_tx_tvalid;
  logic        host_tx_tready;
  logic [7:0]  host_rx_tdata;
  logic        host_rx_tvalid;
  logic        host_rx_tready;

  always #5 clk = ~clk;

  ccw_engine #(.COUNT_WIDTH(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_addr              (req_addr),
    .req_command           (req_command),
    .req_count             (req_count),
`ifdef CCW_SLI_EN
    .req_sli               (req_sli),
`endif
    .done_valid            (done_valid),
    .done_cc               (done_cc),
    .done_status           (done_status),
    .done_residual         (done_residual),
    .done_incorrect_length (done_incorrect_length),
    .chan_addr             (chan_addr),
    .chan_command          (chan_command),
    .chan_start            (chan_start),
    .chan_stop             (chan_stop),
    .chan_active           (chan_active),
    .chan_condition_code   (chan_condition_code),
    .chan_status_tdata     (chan_status_tdata),
    .chan_status_tvalid    (chan_status_tvalid),
    .chan_send_tdata       (chan_send_tdata),
    .chan_send_tvalid      (chan_send_tvalid),
    .chan_send_tready      (chan_send_tready),
    .chan_recv_tdata       (chan_recv_tdata),
    .chan_recv_tvalid      (chan_recv_tvalid),
    .chan_recv_tready      (chan_recv_tready),
    .host_tx_tdata         (host_tx_tdata),
    .host_tx_tvalid        (host_tx_tvalid),
    .host_tx_tready        (host_tx_tready),
    .host_rx_tdata         (host_rx_tdata),
    .host_rx_tvalid        (host_rx_tvalid),
    .host_rx_tready        (host_rx_tready)
  );

  typedef struct {
    logic [1:0]  cc;
    logic [7:0]  st;
    logic [15:0] res;
    logic        il;
  } done_t;

  int checks   = 0;
  int failures = 0;
  int stop_seen = 0;
  int done_seen = 0;

  logic [7:0] exp_send_q[$];
  logic [7:0] exp_rx_q[$];
  done_t      exp_done_q[$];
  logic [7:0] tx_src[$];

  bit acc, tx_hs, snd_hs, rcv_hs, stop_now, start_now;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (chan_send_tvalid && chan_send_tready) begin
        checks++;
        if (exp_send_q.size() == 0) begin
          failures++;
          $display("FAIL send_extra actual=%0h expected=none",
                   chan_send_tdata);
        end else if (chan_send_tdata !== exp_send_q[0]) begin
          failures++;
          $display("FAIL send_byte actual=%0h expected=%0h",
                   chan_send_tdata, exp_send_q[0]);
          void'(exp_send_q.pop_front());
        end else begin
          void'(exp_send_q.pop_front());
        end
      end
      if (host_rx_tvalid && host_rx_tready) begin
        checks++;
        if (exp_rx_q.size() == 0) begin
          failures++;
          $display("FAIL rx_extra actual=%0h expected=none",
                   host_rx_tdata);
        end else if (host_rx_tdata !== exp_rx_q[0]) begin
          failures++;
          $display("FAIL rx_byte actual=%0h expected=%0h",
                   host_rx_tdata, exp_rx_q[0]);
          void'(exp_rx_q.pop_front());
        end else begin
          void'(exp_rx_q.pop_front());
        end
      end
      if (chan_stop) stop_seen++;
      if (done_valid) begin
        done_seen++;
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_extra actual=1 expected=0");
        end else begin
          done_t e;
          e = exp_done_q.pop_front();
          chk("done_cc", done_cc, e.cc);
          chk("done_status", done_status, e.st);
          chk("done_residual", done_residual, e.res);
          chk("done_il", done_incorrect_length, e.il);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    acc       = req_valid && req_ready;
    tx_hs     = host_tx_tvalid && host_tx_tready;
    snd_hs    = chan_send_tvalid && chan_send_tready;
    rcv_hs    = chan_recv_tvalid && chan_recv_tready;
    stop_now  = chan_stop;
    start_now = chan_start;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_host_tx();
    if (tx_src.size() > 0) begin
      host_tx_tvalid = 1'b1;
      host_tx_tdata  = tx_src[0];
    end else begin
      host_tx_tvalid = 1'b0;
      host_tx_tdata  = 8'h00;
    end
  endtask

  task automatic issue(input logic [7:0] addr, input logic [7:0] cmd,
                       input logic [15:0] cnt, input bit sli);
    bit got;
    req_valid   = 1'b1;
    req_addr    = addr;
    req_command = cmd;
    req_count   = cnt;
`ifdef CCW_SLI_EN
    req_sli     = sli;
`else
    if (sli) req_addr = addr;
`endif
    step();
    chk("req_accept", acc, 1);
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      got = start_now;
    end
    chk("start_seen", got, 1);
    chk("chan_addr", chan_addr, addr);
    chk("chan_command", chan_command, cmd);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 12 && done_seen == d0; i++) step();
    chk("done_count", done_seen - d0, 1);
  endtask

  // dev_n < 0: device never goes active and reports cc.
  task automatic do_op(input logic [7:0] addr, input logic [7:0] cmd,
                       input logic [15:0] cnt, input bit sli,
                       input int dev_n, input logic [1:0] cc,
                       input logic [7:0] status, input int stall_after,
                       input logic [15:0] exp_res, input bit exp_il,
                       input int exp_stops);
    bit   wr;
    int   xfer, done_n, guard, stall_left, s0, d0;
    bit   stopped, stalling;
    done_t e;
    wr = cmd[0];
    xfer = (dev_n < 0) ? 0 : ((dev_n < int'(cnt)) ? dev_n : int'(cnt));
    for (int i = 0; i < xfer; i++) begin
      if (wr) exp_send_q.push_back(8'h40 + 8'(i));
      else    exp_rx_q.push_back(8'h80 + 8'(i));
    end
    if (wr)
      for (int i = 0; i < xfer + 3; i++) tx_src.push_back(8'h40 + 8'(i));
    e.cc = cc; e.st = status; e.res = exp_res; e.il = exp_il;
    exp_done_q.push_back(e);
    s0 = stop_seen;
    d0 = done_seen;
    issue(addr, cmd, cnt, sli);
    if (dev_n < 0) begin
      chan_condition_code = cc;
      wait_done(d0);
    end else begin
      chan_active = 1'b1;
      done_n = 0; guard = 0; stall_left = 10; stopped = 1'b0;
      while (done_n < dev_n && !stopped && guard < 200) begin
        if (wr) begin
          chan_send_tready = 1'b1;
        end else begin
          chan_recv_tvalid = 1'b1;
          chan_recv_tdata  = 8'h80 + 8'(done_n);
        end
        stalling = (stall_after >= 0) && (done_n == stall_after)
                && (stall_left > 0);
        host_rx_tready = !stalling;
        if (stalling) stall_left--;
        drive_host_tx();
        step();
        if (stalling) chk("stall_no_recv", rcv_hs, 0);
        if (snd_hs || rcv_hs) done_n++;
        if (tx_hs) void'(tx_src.pop_front());
        if (stop_now) stopped = 1'b1;
        guard++;
      end
      chk("xfer_bounded", guard < 200, 1);
      chan_send_tready   = 1'b0;
      chan_recv_tvalid   = 1'b0;
      chan_recv_tdata    = 8'h00;
      host_rx_tready     = 1'b1;
      host_tx_tvalid     = 1'b0;
      chan_status_tvalid = 1'b1;
      chan_status_tdata  = status;
      step();
      chan_status_tvalid  = 1'b0;
      chan_status_tdata   = 8'h00;
      chan_condition_code = cc;
      chan_active         = 1'b0;
      wait_done(d0);
    end
    chan_condition_code = 2'd0;
    chk("stop_pulses", stop_seen - s0, exp_stops);
    chk("send_q_left", exp_send_q.size(), 0);
    chk("rx_q_left", exp_rx_q.size(), 0);
    tx_src.delete();
    host_tx_tvalid = 1'b0;
    host_tx_tdata  = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_done_rec"},
        {done_cc, done_status, done_residual, done_incorrect_length}, 0);
    chk({tag, "_chan_ctl"}, {chan_addr, chan_command, chan_start,
        chan_stop}, 0);
    chk({tag, "_streams"}, {chan_send_tvalid, chan_recv_tready,
        host_tx_tready, host_rx_tvalid, chan_send_tdata, host_rx_tdata}, 0);
  endtask

  initial begin
    int d0;
    bit stopped_unused;
    reset = 1'b1;
    req_valid = 1'b0; req_addr = 8'h00; req_command = 8'h00;
    req_count = 16'd0;
`ifdef CCW_SLI_EN
    req_sli = 1'b0;
`endif
    chan_active = 1'b0; chan_condition_code = 2'd0;
    chan_status_tdata = 8'h00; chan_status_tvalid = 1'b0;
    chan_send_tready = 1'b0; chan_recv_tdata = 8'h00;
    chan_recv_tvalid = 1'b0; host_tx_tdata = 8'h00;
    host_tx_tvalid = 1'b0; host_rx_tready = 1'b1;
    stopped_unused = 1'b0;
    #12;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    check_reset_outputs("idle0");

    do_op(8'h1A, 8'h01, 16'd4, 1'b0, 4, 2'd0, 8'h0C, -1, 16'd0, 1'b0, 0);
    do_op(8'h2B, 8'h02, 16'd2, 1'b0, 5, 2'd0, 8'h0C, -1, 16'd0, 1'b1, 1);
`ifdef CCW_SLI_EN
    do_op(8'h2C, 8'h02, 16'd8, 1'b1, 3, 2'd0, 8'h0C, -1, 16'd5, 1'b0, 0);
`else
    do_op(8'h2C, 8'h02, 16'd8, 1'b0, 3, 2'd0, 8'h0C, -1, 16'd5, 1'b1, 0);
`endif
    do_op(8'h3D, 8'h01, 16'd4, 1'b0, -1, 2'd3, 8'h00, -1, 16'd4, 1'b1, 0);
    do_op(8'h4E, 8'h02, 16'd6, 1'b0, 6, 2'd0, 8'h0C, 3, 16'd0, 1'b0, 0);
    do_op(8'h5F, 8'h00, 16'd0, 1'b0, 0, 2'd0, 8'h0C, -1, 16'd0, 1'b0, 0);
    do_op(8'h60, 8'h02, 16'd0, 1'b0, 1, 2'd0, 8'h0C, -1, 16'd0, 1'b1, 1);

    // Reset in RUN with three bytes still owed.
    exp_rx_q.push_back(8'h80);
    exp_rx_q.push_back(8'h81);
    d0 = done_seen;
    issue(8'h71, 8'h02, 16'd5, 1'b0);
    chan_active = 1'b1;
    for (int n = 0, g = 0; n < 2 && g < 20; g++) begin
      chan_recv_tvalid = 1'b1;
      chan_recv_tdata  = 8'h80 + 8'(n);
      step();
      if (rcv_hs) n++;
    end
    chan_recv_tvalid = 1'b0;
    chan_recv_tdata  = 8'h00;
    chk("rx_before_reset", exp_rx_q.size(), 0);
    #2;
    reset = 1'b1;
    chan_active = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("no_done_after_reset", done_seen - d0, 0);
    check_reset_outputs("idle1");

    do_op(8'h1A, 8'h01, 16'd4, 1'b0, 4, 2'd0, 8'h0C, -1, 16'd0, 1'b0, 0);
    chk("done_q_left", exp_done_q.size(), 0);
    chk("unused_flag", stopped_unused, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
